// File: rtl/instruction_issue_queue.sv
// In-order instruction issue queue: accepts fetched instructions, issues the oldest unissued
// entry to its execution unit, tracks each entry by reservation-station tag and retires
// completed entries strictly in program order.
module instruction_issue_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned UNIT_BITS = 3,
  parameter int unsigned NUM_UNITS = 8,
  parameter int unsigned TAG_W     = 6,
  localparam int unsigned PTR_W    = $clog2(DEPTH)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       fetch_valid,
  input  logic [31:0]                fetch_instr,
  output logic                       fetch_ready,
  input  logic [NUM_UNITS-1:0]       unit_ready,
  input  logic [NUM_UNITS*TAG_W-1:0] unit_rs_tag,
  output logic                       issue_valid,
  output logic [5:0]                 issue_opcode,
  output logic [UNIT_BITS-1:0]       issue_unit,
  output logic [4:0]                 issue_dest,
  output logic [4:0]                 issue_a,
  output logic [4:0]                 issue_b,
  output logic [TAG_W-1:0]           issue_tag,
  input  logic                       exec_valid,
  input  logic [TAG_W-1:0]           exec_tag,
  input  logic                       wb_valid,
  input  logic [TAG_W-1:0]           wb_tag,
  output logic                       retire_valid,
  output logic [31:0]                retire_instr,
  output logic [PTR_W:0]             count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned CntW = PTR_W + 1;

  typedef enum logic [2:0] {
    StFree,
    StFetched,
    StIssued,
    StExecuting,
    StDone
  } entry_state_e;

  entry_state_e            state_q [DEPTH];
  entry_state_e            state_d [DEPTH];
  logic [31:0]             instr_q [DEPTH];
  logic [31:0]             instr_d [DEPTH];
  logic [TAG_W-1:0]        tag_q   [DEPTH];
  logic [TAG_W-1:0]        tag_d   [DEPTH];

  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        iptr_q, iptr_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [CntW-1:0]         count_q, count_d;

  logic                    issue_valid_q, issue_valid_d;
  logic [5:0]              issue_opcode_q, issue_opcode_d;
  logic [UNIT_BITS-1:0]    issue_unit_q, issue_unit_d;
  logic [4:0]              issue_dest_q, issue_dest_d;
  logic [4:0]              issue_a_q, issue_a_d;
  logic [4:0]              issue_b_q, issue_b_d;
  logic [TAG_W-1:0]        issue_tag_q, issue_tag_d;
  logic                    retire_valid_q, retire_valid_d;
  logic [31:0]             retire_instr_q, retire_instr_d;

  logic [31:0]             cand_instr;
  logic [UNIT_BITS-1:0]    cand_unit;
  logic [TAG_W-1:0]        cand_tag;
  logic                    do_enq, do_issue, do_retire;

  // Status derived from the registered count so a same-cycle retire never frees a slot early.
  assign full        = (count_q == CntW'(DEPTH));
  assign empty       = (count_q == '0);
  assign fetch_ready = ~full;
  assign count       = count_q;

  assign issue_valid  = issue_valid_q;
  assign issue_opcode = issue_opcode_q;
  assign issue_unit   = issue_unit_q;
  assign issue_dest   = issue_dest_q;
  assign issue_a      = issue_a_q;
  assign issue_b      = issue_b_q;
  assign issue_tag    = issue_tag_q;
  assign retire_valid = retire_valid_q;
  assign retire_instr = retire_instr_q;

  // Oldest unissued entry and the unit/tag it would bind to.
  always_comb begin
    cand_instr = instr_q[iptr_q];
    cand_unit  = cand_instr[31 -: UNIT_BITS];
    cand_tag   = unit_rs_tag[int'(cand_unit)*TAG_W +: TAG_W];
    // A FETCHED entry at issue_ptr is unambiguous even when the queue is full.
    do_issue   = ~flush && (state_q[iptr_q] == StFetched) && unit_ready[cand_unit];
    do_retire  = ~flush && (state_q[head_q] == StDone);
    do_enq     = ~flush && fetch_valid && ~full;
  end

  // Next-state for entries, pointers, count and the registered issue/retire outputs.
  always_comb begin
    state_d        = state_q;
    instr_d        = instr_q;
    tag_d          = tag_q;
    head_d         = head_q;
    iptr_d         = iptr_q;
    tail_d         = tail_q;
    count_d        = count_q;
    issue_valid_d  = 1'b0;
    issue_opcode_d = issue_opcode_q;
    issue_unit_d   = issue_unit_q;
    issue_dest_d   = issue_dest_q;
    issue_a_d      = issue_a_q;
    issue_b_d      = issue_b_q;
    issue_tag_d    = issue_tag_q;
    retire_valid_d = 1'b0;
    retire_instr_d = retire_instr_q;

    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        state_d[PTR_W'(i)] = StFree;
      end
      head_d         = '0;
      iptr_d         = '0;
      tail_d         = '0;
      count_d        = '0;
      issue_opcode_d = '0;
      issue_unit_d   = '0;
      issue_dest_d   = '0;
      issue_a_d      = '0;
      issue_b_d      = '0;
      issue_tag_d    = '0;
      retire_instr_d = '0;
    end else begin
      // Tag matching looks only at start-of-cycle state; wb overrides exec on the same entry.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wb_valid && tag_q[PTR_W'(i)] == wb_tag &&
            (state_q[PTR_W'(i)] == StIssued || state_q[PTR_W'(i)] == StExecuting)) begin
          state_d[PTR_W'(i)] = StDone;
        end else if (exec_valid && tag_q[PTR_W'(i)] == exec_tag &&
                     state_q[PTR_W'(i)] == StIssued) begin
          state_d[PTR_W'(i)] = StExecuting;
        end
      end

      if (do_retire) begin
        state_d[head_q] = StFree;
        head_d          = head_q + PTR_W'(1);
        retire_valid_d  = 1'b1;
        retire_instr_d  = instr_q[head_q];
      end

      if (do_issue) begin
        state_d[iptr_q] = StIssued;
        tag_d[iptr_q]   = cand_tag;
        iptr_d          = iptr_q + PTR_W'(1);
        issue_valid_d   = 1'b1;
        issue_opcode_d  = cand_instr[31:26];
        issue_unit_d    = cand_unit;
        issue_dest_d    = cand_instr[15:11];
        issue_a_d       = cand_instr[25:21];
        issue_b_d       = cand_instr[20:16];
        issue_tag_d     = cand_tag;
      end

      if (do_enq) begin
        state_d[tail_q] = StFetched;
        instr_d[tail_q] = fetch_instr;
        tail_d          = tail_q + PTR_W'(1);
      end

      count_d = count_q + CntW'(do_enq) - CntW'(do_retire);
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        state_q[PTR_W'(i)] <= StFree;
        instr_q[PTR_W'(i)] <= '0;
        tag_q[PTR_W'(i)]   <= '0;
      end
      head_q         <= '0;
      iptr_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      issue_valid_q  <= 1'b0;
      issue_opcode_q <= '0;
      issue_unit_q   <= '0;
      issue_dest_q   <= '0;
      issue_a_q      <= '0;
      issue_b_q      <= '0;
      issue_tag_q    <= '0;
      retire_valid_q <= 1'b0;
      retire_instr_q <= '0;
    end else begin
      state_q        <= state_d;
      instr_q        <= instr_d;
      tag_q          <= tag_d;
      head_q         <= head_d;
      iptr_q         <= iptr_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      issue_valid_q  <= issue_valid_d;
      issue_opcode_q <= issue_opcode_d;
      issue_unit_q   <= issue_unit_d;
      issue_dest_q   <= issue_dest_d;
      issue_a_q      <= issue_a_d;
      issue_b_q      <= issue_b_d;
      issue_tag_q    <= issue_tag_d;
      retire_valid_q <= retire_valid_d;
      retire_instr_q <= retire_instr_d;
    end
  end

endmodule

// File: tb/tb_instruction_issue_queue.sv
// Bench for instruction_issue_queue: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based reference model.
module tb_instruction_issue_queue;

  localparam int DEPTH = 8;
  localparam int TAG_W = 6;
  localparam int NU    = 8;

  localparam int SF = 1;  // fetched, not issued
  localparam int SI = 2;  // issued
  localparam int SE = 3;  // executing
  localparam int SD = 4;  // done

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          fetch_valid;
  logic [31:0]   fetch_instr;
  logic          fetch_ready;
  logic [NU-1:0] unit_ready;
  logic [NU*TAG_W-1:0] unit_rs_tag;
  logic          issue_valid;
  logic [5:0]    issue_opcode;
  logic [2:0]    issue_unit;
  logic [4:0]    issue_dest, issue_a, issue_b;
  logic [TAG_W-1:0] issue_tag;
  logic          exec_valid;
  logic [TAG_W-1:0] exec_tag;
  logic          wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic          retire_valid;
  logic [31:0]   retire_instr;
  logic [3:0]    count;
  logic          full, empty;

  instruction_issue_queue #(
    .DEPTH    (DEPTH),
    .UNIT_BITS(3),
    .NUM_UNITS(NU),
    .TAG_W    (TAG_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_ready (fetch_ready),
    .unit_ready  (unit_ready),
    .unit_rs_tag (unit_rs_tag),
    .issue_valid (issue_valid),
    .issue_opcode(issue_opcode),
    .issue_unit  (issue_unit),
    .issue_dest  (issue_dest),
    .issue_a     (issue_a),
    .issue_b     (issue_b),
    .issue_tag   (issue_tag),
    .exec_valid  (exec_valid),
    .exec_tag    (exec_tag),
    .wb_valid    (wb_valid),
    .wb_tag      (wb_tag),
    .retire_valid(retire_valid),
    .retire_instr(retire_instr),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0]      instr;
    logic [TAG_W-1:0] tag;
    int               st;
  } ent_t;

  ent_t mq[$];  // oldest first

  logic             e_iv, e_rv;
  logic [31:0]      e_ri;
  logic [31:0]      e_iinstr;
  logic [TAG_W-1:0] e_tag;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    e_iv     = 1'b0;
    e_rv     = 1'b0;
    e_ri     = '0;
    e_iinstr = '0;
    e_tag    = '0;
  endtask

  // Advance the reference by one clock edge using the currently driven inputs.
  task automatic model_step();
    ent_t nq[$];
    ent_t ne;
    int   iss;
    int   u;
    e_iv = 1'b0;
    e_rv = 1'b0;
    if (flush) begin
      model_clear();
      return;
    end
    nq = mq;
    for (int i = 0; i < mq.size(); i++) begin
      if (wb_valid && (mq[i].st == SI || mq[i].st == SE) && mq[i].tag == wb_tag)
        nq[i].st = SD;
      else if (exec_valid && mq[i].st == SI && mq[i].tag == exec_tag)
        nq[i].st = SE;
    end
    iss = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].st == SF) begin
        iss = i;
        break;
      end
    end
    if (iss >= 0) begin
      u = int'(mq[iss].instr[31:29]);
      if (unit_ready[u]) begin
        e_iv       = 1'b1;
        e_iinstr   = mq[iss].instr;
        e_tag      = unit_rs_tag[u*TAG_W +: TAG_W];
        nq[iss].st  = SI;
        nq[iss].tag = e_tag;
      end
    end
    if (mq.size() > 0 && mq[0].st == SD) begin
      e_rv = 1'b1;
      e_ri = mq[0].instr;
      void'(nq.pop_front());
    end
    if (fetch_valid && mq.size() < DEPTH) begin
      ne.instr = fetch_instr;
      ne.tag   = '0;
      ne.st    = SF;
      nq.push_back(ne);
    end
    mq = nq;
  endtask

  task automatic compare();
    chk("issue_valid", 32'(issue_valid), 32'(e_iv));
    chk("retire_valid", 32'(retire_valid), 32'(e_rv));
    chk("count", 32'(count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("fetch_ready", 32'(fetch_ready), 32'(mq.size() != DEPTH));
    if (e_iv) begin
      chk("issue_opcode", 32'(issue_opcode), 32'(e_iinstr[31:26]));
      chk("issue_unit", 32'(issue_unit), 32'(e_iinstr[31:29]));
      chk("issue_dest", 32'(issue_dest), 32'(e_iinstr[15:11]));
      chk("issue_a", 32'(issue_a), 32'(e_iinstr[25:21]));
      chk("issue_b", 32'(issue_b), 32'(e_iinstr[20:16]));
      chk("issue_tag", 32'(issue_tag), 32'(e_tag));
    end
    if (e_rv) chk("retire_instr", retire_instr, e_ri);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
    compare();
  endtask

  task automatic idle();
    flush       = 1'b0;
    fetch_valid = 1'b0;
    fetch_instr = '0;
    unit_ready  = '0;
    unit_rs_tag = '0;
    exec_valid  = 1'b0;
    exec_tag    = '0;
    wb_valid    = 1'b0;
    wb_tag      = '0;
  endtask

  task automatic do_reset();
    idle();
    #2 reset = 1'b1;
    #1 model_clear();
    #3 reset = 1'b0;
  endtask

  // Random inputs; RS tags offered are always distinct from every in-flight tag.
  task automatic rand_inputs();
    bit   used [64];
    int   t;
    int   live[$];
    int   k;
    flush       = ($urandom_range(0, 99) == 0);
    fetch_valid = ($urandom_range(0, 9) < 7);
    fetch_instr = $urandom;
    unit_ready  = NU'($urandom);
    for (int i = 0; i < 64; i++) used[i] = 1'b0;
    foreach (mq[i]) if (mq[i].st != SF) used[mq[i].tag] = 1'b1;
    t = $urandom_range(0, 63);
    for (int u = 0; u < NU; u++) begin
      while (used[t]) t = (t + 1) % 64;
      used[t] = 1'b1;
      unit_rs_tag[u*TAG_W +: TAG_W] = TAG_W'(t);
    end
    foreach (mq[i]) if (mq[i].st == SI || mq[i].st == SE) live.push_back(i);
    exec_valid = 1'b0;
    wb_valid   = 1'b0;
    exec_tag   = TAG_W'($urandom);
    wb_tag     = TAG_W'($urandom);
    if ($urandom_range(0, 9) < 6) begin
      exec_valid = 1'b1;
      if (live.size() > 0 && $urandom_range(0, 9) < 9) begin
        k = live[$urandom_range(0, live.size() - 1)];
        exec_tag = mq[k].tag;
      end
    end
    if ($urandom_range(0, 9) < 4) begin
      wb_valid = 1'b1;
      if (live.size() > 0 && $urandom_range(0, 9) < 9) begin
        k = live[$urandom_range(0, live.size() - 1)];
        wb_tag = mq[k].tag;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    reset = 1'b1;
    model_clear();
    #12 reset = 1'b0;
    #1;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("reset_issue_valid", 32'(issue_valid), 32'd0);

    // Single unit-0 instruction issues one edge after acceptance with the offered tag.
    fetch_valid = 1'b1;
    fetch_instr = 32'h0000_0000;
    unit_ready  = 8'h01;
    unit_rs_tag[5:0] = 6'h05;
    cycle();
    chk("t2_not_same_edge", 32'(issue_valid), 32'd0);
    fetch_valid = 1'b0;
    cycle();
    chk("t2_issue_valid", 32'(issue_valid), 32'd1);
    chk("t2_issue_tag", 32'(issue_tag), 32'h05);
    cycle();
    chk("t2_pulse_ends", 32'(issue_valid), 32'd0);
    wb_valid = 1'b1;
    wb_tag   = 6'h05;
    cycle();
    wb_valid = 1'b0;
    cycle();
    chk("t2_retire_valid", 32'(retire_valid), 32'd1);
    chk("t2_retire_instr", retire_instr, 32'h0000_0000);

    // Fill to capacity with all units busy; ninth word is refused.
    do_reset();
    fetch_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fetch_instr = 32'h1000_0000 + 32'(i);
      cycle();
    end
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_fetch_ready", 32'(fetch_ready), 32'd0);
    fetch_instr = 32'hDEAD_BEEF;
    cycle();
    chk("t3_count_held", 32'(count), 32'd8);

    // Flush a full queue while fetch is still offering data.
    flush = 1'b1;
    cycle();
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_retire_valid", 32'(retire_valid), 32'd0);
    flush       = 1'b0;
    fetch_valid = 1'b0;
    cycle();
    chk("t6_after", 32'(count), 32'd0);

    // In-order stall: head wants unit 2 which is busy, younger unit-0 entry must wait.
    do_reset();
    unit_ready  = 8'h01;
    unit_rs_tag[2*TAG_W +: TAG_W] = 6'h12;
    unit_rs_tag[0 +: TAG_W]       = 6'h13;
    fetch_valid = 1'b1;
    fetch_instr = 32'h4000_0000;
    cycle();
    fetch_instr = 32'h0000_0001;
    cycle();
    fetch_valid = 1'b0;
    cycle();
    cycle();
    chk("t4_stall", 32'(issue_valid), 32'd0);
    chk("t4_count", 32'(count), 32'd2);
    unit_ready = 8'h05;
    cycle();
    chk("t4_issue_head", 32'(issue_valid), 32'd1);
    chk("t4_head_unit", 32'(issue_unit), 32'd2);
    chk("t4_head_tag", 32'(issue_tag), 32'h12);
    cycle();
    chk("t4_issue_next", 32'(issue_valid), 32'd1);
    chk("t4_next_unit", 32'(issue_unit), 32'd0);
    chk("t4_next_tag", 32'(issue_tag), 32'h13);

    // Out-of-order writeback, in-order retirement on consecutive cycles.
    do_reset();
    unit_ready       = 8'h01;
    unit_rs_tag[5:0] = 6'd3;
    fetch_valid      = 1'b1;
    fetch_instr      = 32'h0000_1111;
    cycle();
    fetch_instr = 32'h0000_2222;
    cycle();
    chk("t5_tag3", 32'(issue_tag), 32'd3);
    fetch_valid      = 1'b0;
    unit_rs_tag[5:0] = 6'd4;
    cycle();
    chk("t5_tag4", 32'(issue_tag), 32'd4);
    wb_valid = 1'b1;
    wb_tag   = 6'd4;
    cycle();
    chk("t5_no_retire_young", 32'(retire_valid), 32'd0);
    wb_tag = 6'd3;
    cycle();
    chk("t5_no_retire_yet", 32'(retire_valid), 32'd0);
    wb_valid = 1'b0;
    cycle();
    chk("t5_retire_first", 32'(retire_valid), 32'd1);
    chk("t5_retire_first_instr", retire_instr, 32'h0000_1111);
    cycle();
    chk("t5_retire_second", 32'(retire_valid), 32'd1);
    chk("t5_retire_second_instr", retire_instr, 32'h0000_2222);
    cycle();
    chk("t5_empty", 32'(empty), 32'd1);

    // Asynchronous reset with five entries queued.
    do_reset();
    fetch_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fetch_instr = 32'h2000_0000 + 32'(i);
      cycle();
    end
    chk("t1_count_before", 32'(count), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_fetch_ready", 32'(fetch_ready), 32'd1);
    chk("t1_issue_valid", 32'(issue_valid), 32'd0);
    model_clear();
    idle();
    #2 reset = 1'b0;

    // Randomized traffic against the reference model.
    repeat (3000) begin
      rand_inputs();
      cycle();
    end

    idle();
    cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
